// File: rtl/jtframe_dwnld_pack_pkg.sv
// Shared types and constants for the download byte-to-word packer.
// Holds the write-side FSM encoding, byte-enable masks and the queued word layout.
package jtframe_dwnld_pack_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_t;

    localparam logic [1:0] MASK_LO = 2'b01;
    localparam logic [1:0] MASK_HI = 2'b10;
    localparam logic [1:0] MASK_W  = 2'b11;

    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } prog_word_t;

    localparam int WORD_W = $bits(prog_word_t);

    // Byte lane of a download byte: odd addresses go high unless bytes are swapped.
    function automatic logic [1:0] lane_mask(input logic odd, input logic swap);
        return (odd ^ swap) ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO with a registered head word.
// A push and a pop in the same cycle both take effect, even when full.
module jtframe_dwnld_fifo #(
    parameter int W  = 40,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam logic [AW:0]   DEPTH   = (AW+1)'(1) << AW;
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [2**AW];
    logic [W-1:0]  head;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + PTR_ONE;
    assign dout    = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The head register follows the next oldest word; an incoming word
    // becomes the head directly when it would be the only entry left.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
        if (do_push && (empty || (do_pop && count == CNT_ONE)))
            head <= din;
        else if (do_pop)
            head <= mem[rd_nxt];
    end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs ROM download bytes into 16-bit SDRAM words with byte enables,
// queues them and issues one held write request per word until acknowledged.
module jtframe_dwnld_pack
    import jtframe_dwnld_pack_pkg::*;
#(
    parameter int FIFO_AW    = 2,
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic        dwnld_busy,
    output logic        overflow
);

    wr_state_t   state;
    prog_word_t  pend_word, head_word;
    logic [WORD_W-1:0] head_bits;
    logic        pend_vld, dl_last, dl_fall, dl_rise;
    logic        wr_en, same_word, lane_hi, push, pop, drop;
    logic        fifo_empty, fifo_full;
    logic [1:0]  byte_mask;

    assign wr_en     = ioctl_wr && downloading;
    assign dl_fall   = dl_last && !downloading;
    assign dl_rise   = !dl_last && downloading;
    assign byte_mask = lane_mask(ioctl_addr[0], SWAP_BYTES);
    assign lane_hi   = (byte_mask == MASK_HI);
    // A completed word is never merged into again; it only waits for its push.
    assign same_word = pend_vld && (pend_word.mask != MASK_W)
                       && (pend_word.addr == ioctl_addr[22:1]);
    assign push      = pend_vld && ((pend_word.mask == MASK_W) || dl_fall
                                    || (wr_en && !same_word));
    assign pop       = (state == ST_REQ) && prog_ack;
    assign drop      = push && fifo_full && !pop;
    assign head_word = prog_word_t'(head_bits);
    assign dwnld_busy = pend_vld || !fifo_empty || prog_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_last  <= 1'b0;
            pend_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            dl_last <= downloading;
            if (wr_en)     pend_vld <= 1'b1;
            else if (push) pend_vld <= 1'b0;
            if (drop)         overflow <= 1'b1;
            else if (dl_rise) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (same_word) begin
                pend_word.mask <= pend_word.mask | byte_mask;
                if (lane_hi) pend_word.data[15:8] <= ioctl_data;
                else         pend_word.data[7:0]  <= ioctl_data;
            end else begin
                pend_word.addr <= ioctl_addr[22:1];
                pend_word.mask <= byte_mask;
                pend_word.data <= lane_hi ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
            end
        end
    end

    jtframe_dwnld_fifo #(
        .W  (WORD_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (pend_word),
        .pop   (pop),
        .dout  (head_bits),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // The head stays queued while requested; it is popped only on acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty) begin
                    prog_addr <= head_word.addr;
                    prog_data <= head_word.data;
                    prog_mask <= head_word.mask;
                    prog_we   <= 1'b1;
                    state     <= ST_REQ;
                end
                ST_REQ: if (prog_ack) begin
                    prog_we <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Scoreboard bench for the download packer: expected words are queued as bytes
// are driven and compared when each write request is acknowledged.
module tb_jtframe_dwnld_pack;

    typedef struct packed {
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, downloading, ioctl_wr;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [21:0] prog_addr, s_prog_addr;
    logic [15:0] prog_data, s_prog_data;
    logic [1:0]  prog_mask, s_prog_mask;
    logic        prog_we, prog_ack, dwnld_busy, overflow;
    logic        s_prog_we, s_prog_ack, s_busy, s_overflow;

    exp_t exp_q[$];
    int   n_vec = 0, n_miss = 0, req_cnt = 0, swap_cnt = 0;
    logic ack_en = 1'b1, swap_on = 1'b0;
    logic [17:0] swap_word;

    always #5 clk = ~clk;

    jtframe_dwnld_pack #(.FIFO_AW(2), .SWAP_BYTES(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_dwnld_pack #(.FIFO_AW(2), .SWAP_BYTES(1'b1)) dut_swap (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(s_prog_addr), .prog_data(s_prog_data), .prog_mask(s_prog_mask),
        .prog_we(s_prog_we), .prog_ack(s_prog_ack),
        .dwnld_busy(s_busy), .overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [22:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!dwnld_busy && exp_q.size() == 0) break;
        end
        check({tag, "_busy"}, 40'(dwnld_busy), 40'(0));
        check({tag, "_left"}, 40'(exp_q.size()), 40'(0));
    endtask

    // Acknowledge arrives one cycle after each request is raised.
    initial begin
        prog_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            prog_ack = ack_en && prog_we && !prog_ack;
        end
    end

    initial begin
        s_prog_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_prog_ack = s_prog_we && !s_prog_ack;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prog_we && prog_ack) begin
                req_cnt++;
                check("req_expected", 40'(exp_q.size() > 0), 40'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("req_addr", 40'(prog_addr), 40'(e.a));
                    check("req_data", 40'(prog_data), 40'(e.d));
                    check("req_mask", 40'(prog_mask), 40'(e.m));
                end
            end
            if (swap_on && s_prog_we && s_prog_ack) begin
                swap_cnt++;
                swap_word = {s_prog_data, s_prog_mask};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        repeat (3) tick();
        check("rst_we",   40'(prog_we),    40'(0));
        check("rst_addr", 40'(prog_addr),  40'(0));
        check("rst_data", 40'(prog_data),  40'(0));
        check("rst_mask", 40'(prog_mask),  40'(0));
        check("rst_ovf",  40'(overflow),   40'(0));
        check("rst_busy", 40'(dwnld_busy), 40'(0));
        rst_n = 1'b1;
        tick();

        // Full word from two bytes, with request latency and swapped-lane twin
        downloading = 1'b1;
        swap_on = 1'b1;
        tick();
        exp_q.push_back('{a: 22'd0, d: 16'h1234, m: 2'b11});
        send_byte(23'h000000, 8'h34);
        send_byte(23'h000001, 8'h12);
        tick();
        check("lat_n1", 40'(prog_we), 40'(0));
        tick();
        check("lat_n2", 40'(prog_we), 40'(1));
        wait_idle("full_word");
        repeat (3) tick();
        swap_on = 1'b0;
        check("swap_cnt",  40'(swap_cnt),        40'(1));
        check("swap_data", 40'(swap_word[17:2]), 40'(16'h3412));
        check("swap_mask", 40'(swap_word[1:0]),  40'(2'b11));

        // Two partial words in different SDRAM words
        exp_q.push_back('{a: 22'd2, d: 16'h00AA, m: 2'b01});
        exp_q.push_back('{a: 22'd4, d: 16'h00BB, m: 2'b01});
        r0 = req_cnt;
        send_byte(23'h000004, 8'hAA);
        send_byte(23'h000008, 8'hBB);
        downloading = 1'b0;
        wait_idle("partial");
        check("partial_cnt", 40'(req_cnt - r0), 40'(2));

        // Lone high byte flushed by the end of the download
        downloading = 1'b1;
        tick();
        exp_q.push_back('{a: 22'd1, d: 16'h5500, m: 2'b10});
        send_byte(23'h000003, 8'h55);
        downloading = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                seen = prog_ack;
            end
            check("flush_ack_seen", 40'(seen), 40'(1));
            check("busy_at_ack", 40'(dwnld_busy), 40'(1));
            tick();
            check("busy_after_ack", 40'(dwnld_busy), 40'(0));
        end
        wait_idle("flush");

        // Overflow with acknowledge withheld: only words 0..3 survive
        ack_en = 1'b0;
        downloading = 1'b1;
        for (int w = 0; w < 4; w++)
            exp_q.push_back('{a: 22'(w), d: {8'(8'h11 + 2*w), 8'(8'h10 + 2*w)}, m: 2'b11});
        r0 = req_cnt;
        for (int i = 0; i < 12; i++) send_byte(23'(i), 8'(8'h10 + i));
        repeat (4) tick();
        check("ovf_set",   40'(overflow),  40'(1));
        check("ovf_we",    40'(prog_we),   40'(1));
        check("ovf_addr0", 40'(prog_addr), 40'(0));
        downloading = 1'b0;
        tick();
        ack_en = 1'b1;
        wait_idle("overflow");
        check("ovf_req_cnt", 40'(req_cnt - r0), 40'(4));
        check("ovf_sticky",  40'(overflow),     40'(1));
        downloading = 1'b1;
        tick();
        check("ovf_clear", 40'(overflow), 40'(0));

        // Reset in the middle of a download discards queued words
        ack_en = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(23'h000200 + 23'(i), 8'(8'h60 + i));
        repeat (3) tick();
        check("pre_rst_busy", 40'(dwnld_busy), 40'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",   40'(prog_we),    40'(0));
        check("mid_rst_busy", 40'(dwnld_busy), 40'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        ack_en = 1'b1;
        r0 = req_cnt;
        repeat (20) tick();
        check("post_rst_req",  40'(req_cnt - r0), 40'(0));
        check("post_rst_busy", 40'(dwnld_busy),   40'(0));
        check("post_rst_we",   40'(prog_we),      40'(0));

        // Byte strobes outside the download window are ignored
        downloading = 1'b0;
        tick();
        r0 = req_cnt;
        send_byte(23'h000300, 8'h77);
        repeat (5) tick();
        check("idle_wr_busy", 40'(dwnld_busy),   40'(0));
        check("idle_wr_req",  40'(req_cnt - r0), 40'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
